// File: rtl/fp_align_sub.sv
// fp_align_sub: exponent difference and mantissa alignment stage; ALIGN_FAST_SHIFT_EN selects a one-cycle barrel shift.
module fp_align_sub #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_max,
  output logic [MAN_W-1:0] man_big,
  output logic [MAN_W+1:0] man_small,
  output logic             sticky,
  output logic             swap
);
  localparam int SW = MAN_W + 2;
  localparam int CW = $clog2(SW + 1);
  typedef enum logic [1:0] {IDLE, DIFF, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic [EXP_W:0] d, mag;
  logic neg;
  logic [CW-1:0] cnt_new;
  logic [SW-1:0] small_pre;
`ifndef ALIGN_FAST_SHIFT_EN
  logic [CW-1:0] cnt;
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // Exponent difference, operand selection and saturated shift amount.
  always_comb begin
    d = {1'b0, ea} - {1'b0, eb};
    neg = d[EXP_W];
    mag = neg ? -d : d;
    cnt_new = (int'(mag) > SW) ? CW'(SW) : CW'(mag);
    small_pre = neg ? {ma, 2'b00} : {mb, 2'b00};
  end
  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? DIFF : IDLE;
`ifdef ALIGN_FAST_SHIFT_EN
      DIFF: state_nx = DONE;
`else
      DIFF: state_nx = (cnt_new == '0) ? DONE : SHIFT;
      SHIFT: state_nx = (cnt == CW'(1)) ? DONE : SHIFT;
`endif
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Operand capture, alignment datapath and held outputs.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ea <= '0;
      eb <= '0;
      ma <= '0;
      mb <= '0;
      exp_max <= '0;
      man_big <= '0;
      man_small <= '0;
      sticky <= 1'b0;
      swap <= 1'b0;
`ifndef ALIGN_FAST_SHIFT_EN
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ea <= exp_a;
          eb <= exp_b;
          ma <= man_a;
          mb <= man_b;
        end
        DIFF: begin
          swap <= neg;
          exp_max <= neg ? eb : ea;
          man_big <= neg ? mb : ma;
`ifdef ALIGN_FAST_SHIFT_EN
          man_small <= small_pre >> cnt_new;
          sticky <= |(small_pre & ~({SW{1'b1}} << cnt_new));
`else
          man_small <= small_pre;
          sticky <= 1'b0;
          cnt <= cnt_new;
`endif
        end
`ifndef ALIGN_FAST_SHIFT_EN
        SHIFT: begin
          man_small <= man_small >> 1;
          sticky <= sticky | man_small[0];
          cnt <= cnt - CW'(1);
        end
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fp_align_sub.sv
// tb_fp_align_sub: directed checks of fp_align_sub alignment, latency, backpressure and reset.
module tb_fp_align_sub;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [4:0] exp_a = 0, exp_b = 0, exp_max;
  logic [10:0] man_a = 0, man_b = 0, man_big;
  logic [12:0] man_small;
  logic in_ready, out_valid, sticky, swap;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fp_align_sub dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready), .exp_max(exp_max),
    .man_big(man_big), .man_small(man_small), .sticky(sticky), .swap(swap)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic run(input string tag, input logic [4:0] ea, input logic [4:0] eb,
                     input logic [10:0] ma, input logic [10:0] mb, input logic e_swap,
                     input logic [4:0] e_exp, input logic [10:0] e_big, input logic [12:0] e_small,
                     input logic e_sticky, input int lat_slow, input int hold);
    int n, lat;
`ifdef ALIGN_FAST_SHIFT_EN
    lat = 2;
`else
    lat = lat_slow;
`endif
    @(negedge clk);
    chk({tag, "_ready_before"}, in_ready, 1);
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb; in_valid = 1;
    @(posedge clk);
    n = 1;
    #1 in_valid = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    chk({tag, "_swap"}, swap, e_swap);
    chk({tag, "_exp_max"}, exp_max, e_exp);
    chk({tag, "_man_big"}, man_big, e_big);
    chk({tag, "_man_small"}, man_small, e_small);
    chk({tag, "_sticky"}, sticky, e_sticky);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_small"}, man_small, e_small);
      chk({tag, "_hold_sticky"}, sticky, e_sticky);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_out_valid_after"}, out_valid, 0);
    out_ready = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exp_max", exp_max, 0);
    chk("rst_man_big", man_big, 0);
    chk("rst_man_small", man_small, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_swap", swap, 0);
    @(negedge clk);
    rst_n = 1;
    run("a_gt_b", 5'd10, 5'd7, 11'h400, 11'h405, 0, 5'd10, 11'h400, 13'h0202, 1, 5, 0);
    run("b_gt_a", 5'd3, 5'd9, 11'h7FF, 11'h400, 1, 5'd9, 11'h400, 13'h007F, 1, 8, 0);
    run("equal", 5'd12, 5'd12, 11'h5A5, 11'h3C3, 0, 5'd12, 11'h5A5, 13'h0F0C, 0, 2, 0);
    run("sat_a", 5'd31, 5'd0, 11'h400, 11'h001, 0, 5'd31, 11'h400, 13'h0000, 1, 15, 0);
    run("sat_b_zero", 5'd0, 5'd31, 11'h000, 11'h7FF, 1, 5'd31, 11'h7FF, 13'h0000, 0, 15, 0);
    run("diff13", 5'd14, 5'd1, 11'h555, 11'h7FF, 0, 5'd14, 11'h555, 13'h0000, 1, 15, 0);
    run("backpressure", 5'd10, 5'd7, 11'h400, 11'h405, 0, 5'd10, 11'h400, 13'h0202, 1, 5, 6);
    @(negedge clk);
    exp_a = 5'd10; exp_b = 5'd7; man_a = 11'h400; man_b = 11'h405; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_man_small", man_small, 0);
    @(negedge clk);
    rst_n = 1;
    run("after_rst", 5'd12, 5'd12, 11'h5A5, 11'h3C3, 0, 5'd12, 11'h5A5, 13'h0F0C, 0, 2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_align_sub.md
# fp_align_sub

- Exponent-difference and mantissa-alignment stage for the floating-point add path.
- Subtracts two EXP_W-bit exponents in two's complement, selects the operand with the larger exponent, and right-shifts the smaller mantissa by the difference, one bit per cycle.
- Produces guard, round and sticky bits for the downstream adder.
- Sits between operand unpacking and the mantissa sum adder, with valid/ready handshakes on both sides.

## Interface
- EXP_W, 5: exponent width.
- MAN_W, 11: mantissa width, hidden bit included.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- exp_a, exp_b  input  EXP_W  biased exponents.
- man_a, man_b  input  MAN_W  mantissas.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  consumer accepts result.
- exp_max  output  EXP_W  larger exponent.
- man_big  output  MAN_W  mantissa of the larger-exponent operand.
- man_small  output  MAN_W+2  aligned smaller mantissa; 2 LSBs are guard and round.
- sticky  output  1  OR of all bits shifted below the round bit.
- swap  output  1  1 when operand b had the larger exponent.

## Operation
- FSM states: IDLE, DIFF, SHIFT, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: capture the operands, go to DIFF.
- **DIFF** (one cycle)
  - d = {0,exp_a} - {0,exp_b}, computed in EXP_W+1 bits.
  - If the sign bit is 1: swap=1 and count=-d. Otherwise swap=0 and count=d.
  - Equal exponents give swap=0.
  - count saturates to MAN_W+2.
  - Load exp_max and man_big. Load the shift register with {smaller-exponent mantissa, 2'b00}. Clear sticky.
  - Next state: DONE if count==0, else SHIFT.
- **SHIFT**
  - Each cycle: register shifts right by 1, sticky |= old LSB, count decrements.
  - When count reaches 0, go to DONE.
- **DONE**
  - out_valid=1; all outputs held stable.
  - On out_ready: return to IDLE.
- in_ready=0 in every state except IDLE. Only one operation is in flight.
- Saturated shift: man_small=0, and sticky = OR of the entire smaller mantissa.

## Timing
- Reset values: in_ready=1 is combinational from IDLE; all other outputs are 0; state=IDLE.
- Latency: out_valid rises min(|d|, MAN_W+2)+2 rising edges after the accepting edge.
  - Minimum is 2 (d=0).
  - Maximum is MAN_W+4 = 15.
- Throughput: the next operands can be accepted no earlier than the edge after the out handshake.
  - in_ready rises on the out_valid&&out_ready edge.
- out_ready may be high before DONE; it is ignored until out_valid=1.
- Backpressure: outputs remain unchanged for any number of cycles while out_ready=0.
- rst_n low in any state: immediate return to IDLE, out_valid=0, in-flight operation discarded.
- rst_n release: first acceptance is possible on the first edge after deassertion.

## Configuration
- ALIGN_FAST_SHIFT_EN
- **Defined:**
  - DIFF is followed directly by DONE on the next edge.
  - A single-cycle barrel shift on the DONE transition produces man_small and sticky.
  - Latency is a constant 2 edges. The SHIFT state and its counter are not generated.
- **Undefined:** iterative one-bit-per-cycle shifter as described above.
- Outputs are bit-identical in both builds; only latency differs.

## Test plan
- exp_a=10, exp_b=7, man_a=11'h400, man_b=11'h405 -> swap=0, exp_max=10, man_big=11'h400, man_small=13'h0202, sticky=1, out_valid 5 edges after accept.
- exp_a=3, exp_b=9, man_a=11'h7FF, man_b=11'h400 -> swap=1, exp_max=9, man_big=11'h400, man_small=13'h007F, sticky=1, latency 8.
- exp_a=exp_b=12, man_a=11'h5A5, man_b=11'h3C3 -> swap=0, man_big=11'h5A5, man_small=13'h0F0C, sticky=0, latency 2.
- exp_a=31, exp_b=0, man_b=11'h001 -> count saturates at 13, man_small=0, sticky=1, latency 15 (2 with ALIGN_FAST_SHIFT_EN).
- Hold out_ready=0 for 6 cycles in DONE -> outputs stable, in_ready=0 throughout; assert out_ready -> in_ready=1 next cycle.
- Pulse rst_n low during SHIFT of the first case -> out_valid=0, state IDLE; the next accepted pair completes normally.
